// File: rtl/param_block_loader.sv
// Streams `count` words from a shared read-only parameter BRAM into a flat register vector.
// The loader owns only the read port signals; the memory itself and any arbitration live outside.
module param_block_loader #(
  parameter int W          = 8,
  parameter int MAX_COUNT  = 64,
  parameter int ADDR_WIDTH = 15,
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = $clog2(MAX_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [W-1:0]           mem_dout,
  output logic [MAX_COUNT*W-1:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_base, r_mem_addr;
  logic [CNT_W-1:0]        r_cnt, r_iss, r_wr, w_cnt_clamp;
  logic [RD_LATENCY-1:0]   r_vld;
  logic                    r_mem_en;
  logic [MAX_COUNT*W-1:0]  r_data;
  logic                    w_idle_like, w_busy, w_accept, w_abort;
  logic                    w_tok, w_last_cap, w_issue;

  assign w_cnt_clamp = (count > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : count;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  // abort wins over start and over a capture in the same cycle
  assign w_accept    = w_idle_like && start && !abort;
  assign w_abort     = w_busy && abort;
  assign w_tok       = r_vld[RD_LATENCY-1];
  assign w_last_cap  = w_tok && (r_wr == r_cnt - CNT_W'(1));
  assign w_issue     = (r_state == S_ISSUE) && (r_iss < r_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = (w_cnt_clamp == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (abort)         w_next = S_IDLE;
        else if (!w_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)           w_next = S_IDLE;
        else if (w_last_cap) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The first read is issued straight from the accept edge, so r_iss counts reads already issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_iss      <= '0;
      r_wr       <= '0;
      r_vld      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_data     <= '0;
    end else if (w_abort) begin
      r_mem_en <= 1'b0;
      r_vld    <= '0;
    end else if (w_accept) begin
      r_base <= base_addr;
      r_cnt  <= w_cnt_clamp;
      r_wr   <= '0;
      r_vld  <= '0;
      r_data <= '0;
      if (w_cnt_clamp != '0) begin
        r_mem_en   <= 1'b1;
        r_mem_addr <= base_addr;
        r_iss      <= CNT_W'(1);
      end else begin
        r_mem_en <= 1'b0;
        r_iss    <= '0;
      end
    end else begin
      r_vld[0] <= r_mem_en;
      for (int unsigned j = 1; j < RD_LATENCY; j++) r_vld[j] <= r_vld[j-1];
      if (w_issue) begin
        r_mem_en   <= 1'b1;
        r_mem_addr <= r_base + ADDR_WIDTH'(r_iss);
        r_iss      <= r_iss + CNT_W'(1);
      end else begin
        r_mem_en <= 1'b0;
      end
      if (w_tok) r_wr <= r_wr + CNT_W'(1);
      for (int unsigned i = 0; i < MAX_COUNT; i++)
        if (w_tok && (r_wr == CNT_W'(i))) r_data[i*W +: W] <= mem_dout;
    end
  end

  assign busy     = w_busy;
  assign done     = (r_state == S_DONE);
  assign mem_en   = r_mem_en;
  assign mem_addr = r_mem_addr;
  assign data_out = r_data;

endmodule

// File: tb/tb_param_block_loader.sv
// Bench for param_block_loader: three instances (read latency 1, 2, 4) share one stimulus
// and are compared every cycle against a per-load arithmetic model of the expected outputs.
module tb_param_block_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] base_addr = '0;
  logic [6:0]  count = '0;

  logic         busy_w [3];
  logic         done_w [3];
  logic         en_w   [3];
  logic [14:0]  addr_w [3];
  logic [7:0]   dout_w [3];
  logic [511:0] data_w [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [14:0] a);
    return a[7:0] + 8'h11;
  endfunction

  function automatic int lat(input int n);
    return (n == 0) ? 1 : (n == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [7:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= en_w[g] ? memf(addr_w[g]) : 8'($urandom);
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign dout_w[g] = pipe[L-1];

    param_block_loader #(
      .W(8), .MAX_COUNT(64), .ADDR_WIDTH(15), .RD_LATENCY(L)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .count(count),
      .busy(busy_w[g]), .done(done_w[g]), .mem_en(en_w[g]), .mem_addr(addr_w[g]),
      .mem_dout(dout_w[g]), .data_out(data_w[g])
    );
  end

  // Reference model: each load is described by its start edge, base and length.
  int          k;
  int          m_t0   [3];
  int          m_cnt  [3];
  logic [14:0] m_base [3];
  logic [14:0] m_addr [3];
  bit          m_busy [3];
  bit          m_done [3];
  bit          m_en   [3];
  logic [7:0]  m_data [3][64];

  task automatic model_reset();
    k = 0;
    for (int n = 0; n < 3; n++) begin
      m_t0[n] = 0; m_cnt[n] = 0; m_base[n] = '0; m_addr[n] = '0;
      m_busy[n] = 0; m_done[n] = 0; m_en[n] = 0;
      for (int i = 0; i < 64; i++) m_data[n][i] = '0;
    end
  endtask

  task automatic model_step();
    int d, i, L;
    k++;
    for (int n = 0; n < 3; n++) begin
      L = lat(n);
      if (m_busy[n] && abort) begin
        m_busy[n] = 0;
        m_en[n]   = 0;
      end else if (!m_busy[n] && start && !abort) begin
        m_t0[n]   = k;
        m_base[n] = base_addr;
        m_cnt[n]  = (int'(count) > 64) ? 64 : int'(count);
        for (int w = 0; w < 64; w++) m_data[n][w] = '0;
        m_done[n] = (m_cnt[n] == 0);
        m_busy[n] = (m_cnt[n] != 0);
        m_en[n]   = m_busy[n];
        if (m_busy[n]) m_addr[n] = base_addr;
      end else if (m_busy[n]) begin
        d = k - m_t0[n];
        m_en[n] = (d < m_cnt[n]);
        if (m_en[n]) m_addr[n] = 15'(int'(m_base[n]) + d);
        i = d - 1 - L;
        if (i >= 0 && i < m_cnt[n]) m_data[n][i] = memf(15'(int'(m_base[n]) + i));
        if (d == m_cnt[n] + L) begin
          m_busy[n] = 0;
          m_done[n] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [511:0] e;
    if (chk_en) begin
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("busy_L%0d", lat(n)), 64'(busy_w[n]), 64'(m_busy[n]));
        chk($sformatf("done_L%0d", lat(n)), 64'(done_w[n]), 64'(m_done[n]));
        chk($sformatf("mem_en_L%0d", lat(n)), 64'(en_w[n]), 64'(m_en[n]));
        chk($sformatf("mem_addr_L%0d", lat(n)), 64'(addr_w[n]), 64'(m_addr[n]));
        for (int i = 0; i < 64; i++) e[i*8 +: 8] = m_data[n][i];
        n_tests++;
        if (data_w[n] !== e) begin
          n_fail++;
          $display("FAIL data_out_L%0d t=%0t got %h expected %h", lat(n), $time, data_w[n], e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_load(input logic [14:0] b, input logic [6:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    i = 0;
    while ((busy_w[0] | busy_w[1] | busy_w[2]) && i < max_cyc) begin
      tick();
      i++;
    end
    chk("wait_idle_timeout", 64'(busy_w[0] | busy_w[1] | busy_w[2]), 64'd0);
  endtask

  initial begin
    logic [14:0] exp_wrap [4];
    int pulses;
    exp_wrap = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    chk("reset_busy", 64'(busy_w[1]), 64'd0);
    chk("reset_done", 64'(done_w[1]), 64'd0);
    chk("reset_mem_en", 64'(en_w[1]), 64'd0);
    chk("reset_mem_addr", 64'(addr_w[1]), 64'd0);
    chk("reset_data_zero", 64'(|data_w[1]), 64'd0);
    rst_n = 1'b1;
    tick();

    // default load: 8 words from 16408
    start_load(15'd16408, 7'd8);
    for (int d = 0; d <= 12; d++) begin
      chk("t1_mem_en", 64'(en_w[1]), 64'(d < 8));
      if (d < 8) chk("t1_mem_addr", 64'(addr_w[1]), 64'(16408 + d));
      chk("t1_done_L1", 64'(done_w[0]), 64'(d >= 9));
      chk("t1_done_L2", 64'(done_w[1]), 64'(d >= 10));
      chk("t1_done_L4", 64'(done_w[2]), 64'(d >= 12));
      tick();
    end
    for (int i = 0; i < 9; i++)
      chk("t1_word", 64'(data_w[1][i*8 +: 8]), (i < 8) ? 64'(8'h29 + 8'(i)) : 64'd0);

    // zero count and clamping
    start_load(15'd77, 7'd0);
    chk("t2_zero_done", 64'(done_w[0] & done_w[1] & done_w[2]), 64'd1);
    chk("t2_zero_en", 64'(en_w[0] | en_w[1] | en_w[2]), 64'd0);
    tick();
    chk("t2_zero_en_next", 64'(en_w[1]), 64'd0);
    start_load(15'd100, 7'd69);
    pulses = 0;
    for (int c = 0; c < 90; c++) begin
      if (en_w[1]) pulses++;
      tick();
    end
    chk("t2_clamp_reads", 64'(pulses), 64'd64);
    chk("t2_clamp_last_word", 64'(data_w[1][63*8 +: 8]), 64'(memf(15'd163)));
    wait_idle(20);

    // address wrap
    start_load(15'h7FFE, 7'd4);
    for (int d = 0; d < 4; d++) begin
      chk("t3_wrap_addr", 64'(addr_w[1]), 64'(exp_wrap[d]));
      tick();
    end
    wait_idle(20);

    // restart from DONE, with an ignored start while busy
    start_load(15'd500, 7'd3);
    chk("t4_addr0", 64'(addr_w[1]), 64'd500);
    base_addr = 15'd9000;
    count     = 7'd20;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("t4_addr1", 64'(addr_w[1]), 64'd501);
    tick();
    chk("t4_addr2", 64'(addr_w[1]), 64'd502);
    tick();
    chk("t4_en_off", 64'(en_w[1]), 64'd0);
    wait_idle(20);
    for (int i = 0; i < 64; i++)
      chk("t4_word", 64'(data_w[1][i*8 +: 8]), (i < 3) ? 64'(8'h05 + 8'(i)) : 64'd0);

    // abort on the 4th issue cycle
    start_load(15'd1000, 7'd10);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_en", 64'(en_w[0] | en_w[1] | en_w[2]), 64'd0);
    chk("t5_abort_busy", 64'(busy_w[0] | busy_w[1] | busy_w[2]), 64'd0);
    repeat (15) tick();
    chk("t5_abort_done", 64'(done_w[0] | done_w[1] | done_w[2]), 64'd0);
    chk("t5_L2_w0", 64'(data_w[1][7:0]), 64'hF9);
    chk("t5_L2_w1", 64'(data_w[1][15:8]), 64'h00);
    chk("t5_L1_w1", 64'(data_w[0][15:8]), 64'hFA);
    chk("t5_L1_w2", 64'(data_w[0][23:16]), 64'h00);
    chk("t5_L4_w0", 64'(data_w[2][7:0]), 64'h00);

    // asynchronous reset while draining
    start_load(15'd200, 7'd5);
    repeat (6) tick();
    chk("t6_pre_busy", 64'(busy_w[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy_w[1]), 64'd0);
    chk("t6_rst_done", 64'(done_w[1]), 64'd0);
    chk("t6_rst_en", 64'(en_w[1]), 64'd0);
    chk("t6_rst_addr", 64'(addr_w[1]), 64'd0);
    chk("t6_rst_data", 64'(|data_w[1]), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_load(15'd300, 7'd6);
    wait_idle(20);
    chk("t6_clean_w5", 64'(data_w[1][5*8 +: 8]), 64'h42);
    chk("t6_clean_done", 64'(done_w[1]), 64'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom % 100);
      start = 1'b0;
      abort = 1'b0;
      if (r < 10) begin
        start     = 1'b1;
        base_addr = ($urandom % 4 == 0) ? 15'(15'h7FF0 + ($urandom % 16)) : 15'($urandom);
        count     = ($urandom % 5 == 0) ? 7'($urandom_range(60, 70)) : 7'($urandom_range(0, 12));
      end else if (r < 13) begin
        abort = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    wait_idle(100);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
